avalon_arbiter: RTL and testbench
=================================

# avalon_arbiter

Round-robin arbiter that shares one Avalon-MM agent between `NUM_HOSTS` Avalon-MM hosts. It sits between the `AVALON_IF` host ports of several requesters and a single downstream agent, such as a register bank or the MAC configuration space. It holds a grant for the full duration of one transfer and muxes command, data and response. A watchdog terminates a transfer that the agent never acknowledges.

## Interface
- `NUM_HOSTS`, default 2: number of requesting hosts (legal 2–16).
- `TIMEOUT_CYCLES`, default 1024: cycles of continuous agent `waitrequest` before forced termination. 0 disables the watchdog.
- `clk`  input  1  single clock; all state is updated on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `hosts`  `AVALON_IF.Agent` array  [NUM_HOSTS]  upstream ports, one per requester. All instances carry identical width parameters.
- `agent`  `AVALON_IF.Host`  1  downstream port, same widths as `hosts`.

## Operation
- States: `IDLE`, `BUSY`.
- A host requests when `read | write` is high. A host that asserts both `read` and `write` is treated as a write.
- **`IDLE`:**
  - Agent `read`/`write` are 0.
  - Every host sees `waitrequest=1`, `response=0`, `readdata=0`.
  - If any host requests, the winner is the first requesting index strictly after `last_grant`, wrapping modulo `NUM_HOSTS`.
  - The arbiter registers `grant=winner`, clears the timeout counter and moves to `BUSY`.
- **`BUSY`:**
  - `agent.address/byteenable/read/write/writedata` are driven combinationally from `hosts[grant]`.
  - `hosts[grant].waitrequest/readdata/response` are driven from `agent`.
  - Non-granted hosts keep `waitrequest=1`, `readdata=0`, `response=0`.
- **Normal completion:** `agent.waitrequest=0` while the granted host requests. The arbiter sets `last_grant=grant` and goes to `IDLE`.
- **Timeout:** the counter increments each `BUSY` cycle while `agent.waitrequest=1`. When the count reaches `TIMEOUT_CYCLES-1`, the next cycle is a termination cycle:
  - Agent `read`/`write` are forced to 0.
  - The granted host sees `waitrequest=0`, `readdata=0`, `response=2'b10` (SLVERR).
  - The arbiter then sets `last_grant=grant` and goes to `IDLE`.
- **Granted host drops its request in `BUSY`** (a protocol violation): agent `read`/`write` follow the host to 0. The arbiter goes to `IDLE` next cycle, sets `last_grant=grant` and reports no error.
- **Reset mid-transfer:** the transfer is abandoned immediately. The agent sees `read`/`write` drop asynchronously, with no completion to any host.
- **Reset values:** state `IDLE`, `grant=0`, `last_grant=NUM_HOSTS-1` (host 0 has first priority), counter 0, all outputs at their `IDLE` values.
- **Arithmetic:**
  - The grant pointer is `$clog2(NUM_HOSTS)` bits and wraps explicitly, with no reliance on power-of-two overflow.
  - The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.

## Timing
- Arbitration latency is 1 cycle. A request first seen in `IDLE` at cycle n reaches the agent at cycle n+1.
- Completion is combinational. Host `waitrequest` falls in the same cycle as agent `waitrequest`, and `readdata`/`response` are valid in that cycle.
- Minimum transfer occupancy is 2 cycles (`IDLE` + `BUSY`). Back-to-back requests from different hosts alternate with one `IDLE` cycle between transfers.
- A worst-case waiting host is served within `NUM_HOSTS-1` transfers, so the scheme is starvation-free.
- A new request arriving in the completion cycle is not considered until the following `IDLE` cycle.
- Timeout termination occurs exactly `TIMEOUT_CYCLES` cycles after entering `BUSY`.

## Structure
- Shared package `avalon_pkg` holds:
  - `avalon_response_t` enum: `OKAY=2'b00`, `RESERVED=2'b01`, `SLVERR=2'b10`, `DECODEERROR=2'b11`.
  - `arb_state_t` enum: `IDLE`, `BUSY`.
- One sub-module, `rr_picker`, which is combinational. Inputs are the request vector and `last_grant`; outputs are the `winner` index and a `valid` flag. It is reusable by later arbiters.
- The top level contains the FSM, the grant/`last_grant` registers, the timeout counter and the host/agent muxes.

## Test plan
- Single request: host 1 reads address 0x10, and the agent holds `waitrequest` for 3 cycles, then returns 0xDEADBEEF with `OKAY`. Host 1 sees `waitrequest` low once with `readdata=0xDEADBEEF`. The agent sees `read` for 4 cycles starting 1 cycle after the request.
- Fairness: with `NUM_HOSTS=4`, all hosts write continuously and the agent has zero wait. Grants after reset follow 0,1,2,3,0,… with one `IDLE` cycle between transfers.
- Isolation: host 0 is granted while host 1 requests. Host 1 keeps `waitrequest=1`, `readdata=0`, `response=0` until its own grant, and host 0's `writedata` alone reaches the agent.
- Timeout: with `TIMEOUT_CYCLES=8` and the agent stuck in `waitrequest`, host 2's read terminates in cycle 8 of `BUSY` with `response=2'b10`, `readdata=0`. Agent `read` is 0 in that cycle, and the next grant goes to host 3.
- Reset: assert `rst` mid-`BUSY`. The agent sees `read`/`write` drop without waiting for a clock. After release, host 0 is served first when hosts 0 and 1 request simultaneously.

Source files
------------

// File: rtl/avalon_arbiter_pkg.sv
// avalon_pkg
// Shared types for the Avalon-MM arbiter slice: the bus response codes and
// the arbiter state encoding. Imported by the arbiter top and its bench.
package avalon_pkg;

   // Avalon-MM response field encoding
   typedef enum logic [1:0] {
      OKAY        = 2'b00,
      RESERVED    = 2'b01,
      SLVERR      = 2'b10,
      DECODEERROR = 2'b11
   } avalon_response_t;

   // Arbiter states: IDLE picks a winner, BUSY carries one transfer
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/avalon_arbiter_if.sv
// AVALON_IF
// One Avalon-MM port bundle. The Host modport drives the command side
// (address, byteenable, read, write, writedata) and receives the response
// side (waitrequest, readdata, response). The Agent modport is the mirror.
// Parameters: ADDR_W address width, DATA_W data width (multiple of 8).
interface AVALON_IF #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic [1:0]          response;

   modport Host (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, response
   );

   modport Agent (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, response
   );
endinterface

// File: rtl/avalon_arbiter_picker.sv
// rr_picker
// Combinational round-robin picker. Scans the request vector starting at the
// index just after last_grant, wrapping explicitly at N, and returns the first
// requester found.
// Ports: req (one bit per requester), last_grant (previous winner),
//        winner (chosen index), valid (some requester was found).
module rr_picker #(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] winner,
   output logic         valid
);

   // Walk the N candidate positions after last_grant in priority order. The
   // wrap is done by subtraction so non-power-of-two N behaves correctly, and
   // last_grant itself is checked last so a lone requester can win again.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int step = 1; step <= N; step++) begin
         idx = int'(last_grant) + step;
         if (idx >= N) idx = idx - N;
         if (!valid && req[idx]) begin
            winner = W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/avalon_arbiter.sv
// avalon_arbiter
// Round-robin arbiter sharing one Avalon-MM agent between NUM_HOSTS hosts.
// A grant is held for one whole transfer; command goes from the granted host
// to the agent and the response comes back combinationally. A watchdog ends
// a transfer with SLVERR if the agent stalls for TIMEOUT_CYCLES (0 = off).
// Ports: clk, rst (async, active-high), hosts[NUM_HOSTS] (Agent side of each
//        requester's bus), agent (Host side towards the shared agent).
module avalon_arbiter
   import avalon_pkg::*;
#(
   parameter int NUM_HOSTS      = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32
) (
   input  logic    clk,
   input  logic    rst,
   AVALON_IF.Agent hosts [NUM_HOSTS],
   AVALON_IF.Host  agent
);

   localparam int GW = $clog2(NUM_HOSTS);
   localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   arb_state_t      state;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   last_grant;
   logic [CW-1:0]   tcount;

   logic [NUM_HOSTS-1:0] h_read;
   logic [NUM_HOSTS-1:0] h_write;
   logic [NUM_HOSTS-1:0] h_req;
   logic [ADDR_W-1:0]    h_address    [NUM_HOSTS];
   logic [DATA_W/8-1:0]  h_byteenable [NUM_HOSTS];
   logic [DATA_W-1:0]    h_writedata  [NUM_HOSTS];

   logic          busy;
   logic          timeout_now;
   logic          active;
   logic          granted_req;
   logic [GW-1:0] pick_winner;
   logic          pick_valid;

   // Flatten the interface array into plain arrays so the grant index can
   // select a host, and steer the response path back. Only the granted host
   // in BUSY ever sees the agent; everyone else is held off with zeros.
   for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_host
      logic sel;
      assign sel             = busy && (grant == GW'(g));
      assign h_read[g]       = hosts[g].read;
      assign h_write[g]      = hosts[g].write;
      assign h_req[g]        = hosts[g].read | hosts[g].write;
      assign h_address[g]    = hosts[g].address;
      assign h_byteenable[g] = hosts[g].byteenable;
      assign h_writedata[g]  = hosts[g].writedata;

      assign hosts[g].waitrequest = sel ? (timeout_now ? 1'b0 : agent.waitrequest) : 1'b1;
      assign hosts[g].readdata    = (sel && !timeout_now) ? agent.readdata : '0;
      assign hosts[g].response    = !sel ? 2'(OKAY) : (timeout_now ? 2'(SLVERR) : agent.response);
   end

   rr_picker #(
      .N (NUM_HOSTS),
      .W (GW)
   ) u_picker (
      .req        (h_req),
      .last_grant (last_grant),
      .winner     (pick_winner),
      .valid      (pick_valid)
   );

   // The termination cycle is the one where the counter already sits at
   // TIMEOUT_CYCLES-1; in it the agent command is withdrawn. Read and write
   // derive from the state register, so an async reset drops them at once.
   assign busy        = (state == BUSY);
   assign timeout_now = (TIMEOUT_CYCLES != 0) && busy && (tcount == CNT_LIMIT);
   assign active      = busy && !timeout_now;
   assign granted_req = h_req[grant];

   assign agent.address    = h_address[grant];
   assign agent.byteenable = h_byteenable[grant];
   assign agent.writedata  = h_writedata[grant];
   assign agent.read       = active && h_read[grant] && !h_write[grant];
   assign agent.write      = active && h_write[grant];

   // Arbiter FSM with grant, last_grant and watchdog counter. Any BUSY exit
   // (completion, timeout, or the host dropping its request) records the
   // grant as last_grant so the next search starts after it. The counter
   // saturates so a disabled watchdog can never wrap into a false match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GW'(NUM_HOSTS - 1);
         tcount     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant  <= pick_winner;
                  tcount <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (timeout_now || !granted_req || !agent.waitrequest) begin
                  last_grant <= grant;
                  state      <= IDLE;
               end else if (tcount != CNT_MAX) begin
                  tcount <= tcount + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_arbiter.sv
// tb_avalon_arbiter
// Self-checking bench for avalon_arbiter with four hosts and an 8-cycle
// watchdog. A transfer-level reference model (who owns the agent, who was
// served last, how long the current transfer has lasted) predicts every
// host and agent output each cycle; directed phases follow the test plan
// and a randomized phase follows.
module tb_avalon_arbiter;
   import avalon_pkg::*;

   localparam int N  = 4;
   localparam int T  = 8;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   AVALON_IF #(.ADDR_W(AW), .DATA_W(DW)) hosts_if [N] ();
   AVALON_IF #(.ADDR_W(AW), .DATA_W(DW)) agent_if ();

   logic          h_rd    [N];
   logic          h_wr    [N];
   logic [AW-1:0] h_addr  [N];
   logic [DW-1:0] h_wd    [N];
   logic [3:0]    h_be    [N];
   logic          h_wait  [N];
   logic [DW-1:0] h_rdata [N];
   logic [1:0]    h_resp  [N];

   logic          a_wait;
   logic [DW-1:0] a_rdata;
   logic [1:0]    a_resp;

   // Tie the bench's per-host variables onto the interface instances
   for (genvar g = 0; g < N; g++) begin : g_tie
      assign hosts_if[g].read       = h_rd[g];
      assign hosts_if[g].write      = h_wr[g];
      assign hosts_if[g].address    = h_addr[g];
      assign hosts_if[g].writedata  = h_wd[g];
      assign hosts_if[g].byteenable = h_be[g];
      assign h_wait[g]  = hosts_if[g].waitrequest;
      assign h_rdata[g] = hosts_if[g].readdata;
      assign h_resp[g]  = hosts_if[g].response;
   end

   assign agent_if.waitrequest = a_wait;
   assign agent_if.readdata    = a_rdata;
   assign agent_if.response    = a_resp;

   avalon_arbiter #(
      .NUM_HOSTS      (N),
      .TIMEOUT_CYCLES (T),
      .ADDR_W         (AW),
      .DATA_W         (DW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .hosts (hosts_if),
      .agent (agent_if)
   );

   int total;
   int bad;

   // Reference model: owner of the agent (-1 when free), last host served,
   // and number of BUSY cycles already spent in the current transfer
   int owner;
   int lastServed;
   int age;

   // Observation counters used by the directed phases
   int            aReadCycles;
   logic [AW-1:0] lastReadAddr;
   int            writeIds[$];
   int            wlCount [N];
   logic [DW-1:0] wlData  [N];
   logic [1:0]    wlResp  [N];

   // Single comparison point: counts every check, reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      owner      = -1;
      lastServed = N - 1;
      age        = 0;
   endtask

   task automatic clearCounters();
      aReadCycles  = 0;
      lastReadAddr = '0;
      writeIds.delete();
      for (int i = 0; i < N; i++) begin
         wlCount[i] = 0;
         wlData[i]  = '0;
         wlResp[i]  = '0;
      end
   endtask

   task automatic clearInputs();
      for (int i = 0; i < N; i++) begin
         h_rd[i]   = 1'b0;
         h_wr[i]   = 1'b0;
         h_addr[i] = 32'h100 * 32'(i + 1);
         h_wd[i]   = 32'hA000_0000 | 32'(i);
         h_be[i]   = 4'hF;
      end
      a_wait  = 1'b1;
      a_rdata = '0;
      a_resp  = 2'b00;
   endtask

   // One clock cycle: called at a falling edge with inputs already set.
   // Checks every output against the model, records observations, advances
   // the model across the next rising edge, and returns at the next falling
   // edge.
   task automatic applyStimulus();
      bit            busy;
      bit            term;
      int            o;
      int            k;
      logic          expW;
      logic [DW-1:0] expR;
      logic [1:0]    expS;
      #1;
      busy = (owner >= 0);
      o    = busy ? owner : 0;
      term = busy && (age == T - 1);

      checkOutput("agent.read",  64'(agent_if.read),  64'(busy && !term && h_rd[o] && !h_wr[o]));
      checkOutput("agent.write", 64'(agent_if.write), 64'(busy && !term && h_wr[o]));
      if (busy) begin
         checkOutput("agent.address",    64'(agent_if.address),    64'(h_addr[o]));
         checkOutput("agent.writedata",  64'(agent_if.writedata),  64'(h_wd[o]));
         checkOutput("agent.byteenable", 64'(agent_if.byteenable), 64'(h_be[o]));
      end
      for (int i = 0; i < N; i++) begin
         if (busy && i == o) begin
            if (term) begin
               expW = 1'b0; expR = '0; expS = 2'b10;
            end else begin
               expW = a_wait; expR = a_rdata; expS = a_resp;
            end
         end else begin
            expW = 1'b1; expR = '0; expS = 2'b00;
         end
         checkOutput($sformatf("host%0d.waitrequest", i), 64'(h_wait[i]),  64'(expW));
         checkOutput($sformatf("host%0d.readdata", i),    64'(h_rdata[i]), 64'(expR));
         checkOutput($sformatf("host%0d.response", i),    64'(h_resp[i]),  64'(expS));
         if (h_wait[i] === 1'b0) begin
            wlCount[i]++;
            wlData[i] = h_rdata[i];
            wlResp[i] = h_resp[i];
         end
      end
      if (agent_if.read === 1'b1) begin
         aReadCycles++;
         lastReadAddr = agent_if.address;
      end
      if (agent_if.write === 1'b1) writeIds.push_back(int'(agent_if.writedata[3:0]));

      if (rst) begin
         modelReset();
      end else if (busy) begin
         if (term || !(h_rd[o] || h_wr[o]) || !a_wait) begin
            lastServed = o;
            owner      = -1;
         end else begin
            age++;
         end
      end else begin
         for (int s = 1; s <= N; s++) begin
            k = (lastServed + s) % N;
            if (owner < 0 && (h_rd[k] || h_wr[k])) begin
               owner = k;
               age   = 0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   int stuck;

   initial begin
      total = 0;
      bad   = 0;
      stuck = 0;
      clearInputs();
      clearCounters();
      modelReset();
      rst = 1'b1;
      @(negedge clk);

      // Reset state, then one idle cycle after release
      applyStimulus();
      rst = 1'b0;
      applyStimulus();

      // Fairness: all hosts write continuously, agent never waits
      clearCounters();
      for (int i = 0; i < N; i++) h_wr[i] = 1'b1;
      a_wait = 1'b0;
      repeat (24) applyStimulus();
      checkOutput("fair.count", 64'(writeIds.size()), 64'd12);
      for (int i = 0; i < 12; i++)
         checkOutput($sformatf("fair.grant%0d", i),
                     64'((i < writeIds.size()) ? writeIds[i] : -1), 64'(i % N));
      clearInputs();
      applyStimulus();

      // Isolation: host 0 writes with two wait cycles while host 1 reads
      clearCounters();
      h_wr[0] = 1'b1;
      h_wd[0] = 32'h5555_0000;
      h_rd[1] = 1'b1;
      a_rdata = 32'h1234_5678;
      a_wait  = 1'b1;
      repeat (3) applyStimulus();
      a_wait = 1'b0;
      applyStimulus();
      checkOutput("iso.host1_waitlow", 64'(wlCount[1]), 64'd0);
      checkOutput("iso.host0_waitlow", 64'(wlCount[0]), 64'd1);
      checkOutput("iso.write_cycles",  64'(writeIds.size()), 64'd3);
      h_wr[0] = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("iso.host1_served", 64'(wlCount[1]), 64'd1);
      clearInputs();
      applyStimulus();

      // Single request: host 1 reads 0x10, agent stalls 3 cycles
      clearCounters();
      h_addr[1] = 32'h10;
      h_rd[1]   = 1'b1;
      a_wait    = 1'b1;
      repeat (4) applyStimulus();
      a_wait  = 1'b0;
      a_rdata = 32'hDEAD_BEEF;
      a_resp  = 2'b00;
      applyStimulus();
      h_rd[1] = 1'b0;
      a_wait  = 1'b1;
      a_rdata = '0;
      applyStimulus();
      checkOutput("single.read_cycles", 64'(aReadCycles),  64'd4);
      checkOutput("single.waitlow",     64'(wlCount[1]),   64'd1);
      checkOutput("single.readdata",    64'(wlData[1]),    64'hDEAD_BEEF);
      checkOutput("single.address",     64'(lastReadAddr), 64'h10);
      clearInputs();

      // Timeout: host 2 reads into a stuck agent while host 3 waits
      clearCounters();
      h_rd[2] = 1'b1;
      h_rd[3] = 1'b1;
      a_wait  = 1'b1;
      a_rdata = 32'hBAD0_BAD0;
      a_resp  = 2'b01;
      repeat (9) applyStimulus();
      checkOutput("tmo.read_cycles", 64'(aReadCycles), 64'd7);
      checkOutput("tmo.waitlow",     64'(wlCount[2]),  64'd1);
      checkOutput("tmo.readdata",    64'(wlData[2]),   64'd0);
      checkOutput("tmo.response",    64'(wlResp[2]),   64'd2);
      checkOutput("tmo.host3_idle",  64'(wlCount[3]),  64'd0);
      h_rd[2] = 1'b0;
      clearCounters();
      repeat (2) applyStimulus();
      checkOutput("tmo.next_grant", 64'(lastReadAddr), 64'h400);
      a_wait = 1'b0;
      applyStimulus();
      clearInputs();
      applyStimulus();

      // Reset mid-transfer: serve host 0, then put host 1 in BUSY and reset
      h_rd[0] = 1'b1;
      a_wait  = 1'b0;
      repeat (2) applyStimulus();
      h_rd[0] = 1'b0;
      h_rd[1] = 1'b1;
      a_wait  = 1'b1;
      repeat (2) applyStimulus();
      #1;
      checkOutput("rst.pre_read", 64'(agent_if.read), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("rst.async_read",  64'(agent_if.read), 64'd0);
      checkOutput("rst.async_write", 64'(agent_if.write), 64'd0);
      checkOutput("rst.host1_wait",  64'(h_wait[1]), 64'd1);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clearCounters();
      h_rd[0] = 1'b1;
      h_rd[1] = 1'b1;
      a_wait  = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("rst.first_addr", 64'(lastReadAddr), 64'h100);
      checkOutput("rst.host0_done", 64'(wlCount[0]),   64'd1);
      checkOutput("rst.host1_wait", 64'(wlCount[1]),   64'd0);
      clearInputs();
      applyStimulus();

      // Randomized traffic with occasional long stalls to reach the watchdog
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (h_rd[i] || h_wr[i]) begin
               if ($urandom_range(0, 15) == 0) begin
                  h_rd[i] = 1'b0;
                  h_wr[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               h_rd[i] = 1'($urandom);
               h_wr[i] = 1'($urandom);
               if (!h_rd[i] && !h_wr[i]) h_rd[i] = 1'b1;
            end
            h_addr[i] = $urandom;
            h_wd[i]   = $urandom;
            h_be[i]   = 4'($urandom);
         end
         if (stuck > 0) begin
            a_wait = 1'b1;
            stuck--;
         end else begin
            if ($urandom_range(0, 39) == 0) stuck = 10;
            a_wait = ($urandom_range(0, 2) == 0);
         end
         a_rdata = $urandom;
         a_resp  = 2'($urandom);
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
